// File: rtl/nand_rr_scheduler.sv
// nand_rr_scheduler
// Arbitrates four requesters round-robin. For each requester it grants, the
// block computes the bitwise NAND of that requester's operands. It presents
// the result on a valid/ready handshake.
//
// Ports:
//   i_clk      : single clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_req      : per-requester request level (held until granted)
//   i_a, i_b   : packed operands, requester k at [k*WIDTH +: WIDTH]
//   i_ready    : result consumer ready (only looked at while a result is pending)
//   o_gnt      : one-cycle one-hot grant pulse
//   o_data     : registered ~(A & B) of the granted requester
//   o_id       : index of the requester that owns o_data
//   o_valid    : result valid
//   o_busy     : high whenever an operation is in flight
//   o_ops_cnt  : completed handshakes, wraps modulo 256
module nand_rr_scheduler #(
   parameter int WIDTH = 4,
   parameter int N_REQ = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*WIDTH-1:0] i_a,
   input  logic [N_REQ*WIDTH-1:0] i_b,
   input  logic                   i_ready,
   output logic [N_REQ-1:0]       o_gnt,
   output logic [WIDTH-1:0]       o_data,
   output logic [1:0]             o_id,
   output logic                   o_valid,
   output logic                   o_busy,
   output logic [7:0]             o_ops_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [1:0]           ptr_r;
   logic [WIDTH-1:0]     a_lat_r;
   logic [WIDTH-1:0]     b_lat_r;
   logic [1:0]           id_lat_r;
   logic [1:0]           cand_s;
   logic [1:0]           win_idx_s;
   logic                 win_found_s;
   logic [N_REQ-1:0]     gnt_s;

   function automatic logic [WIDTH-1:0] nand_f(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      return ~(a & b);
   endfunction

   // Round-robin pick: scan ptr+1, ptr+2, ... with 2-bit wrap, first requester found wins.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = 2'd0;
      cand_s      = 2'd0;
      gnt_s       = {N_REQ{1'b0}};
      for (int i = 1; i <= 4; i++) begin
         cand_s = ptr_r + 2'(i);
         if (!win_found_s && i_req[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
      if (win_found_s) begin
         gnt_s[win_idx_s] = 1'b1;
      end else begin
         gnt_s = {N_REQ{1'b0}};
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (|i_req) state_nxt_s = ST_EXEC;
            else        state_nxt_s = ST_IDLE;
         end
         ST_EXEC: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (i_ready) state_nxt_s = ST_IDLE;
            else         state_nxt_s = ST_RESP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath: grant/latch in IDLE, compute in EXEC, handshake in RESP.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_r     <= 2'd3;
         a_lat_r   <= {WIDTH{1'b0}};
         b_lat_r   <= {WIDTH{1'b0}};
         id_lat_r  <= 2'd0;
         o_gnt     <= {N_REQ{1'b0}};
         o_data    <= {WIDTH{1'b0}};
         o_id      <= 2'd0;
         o_valid   <= 1'b0;
         o_ops_cnt <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (win_found_s) begin
                  o_gnt    <= gnt_s;
                  a_lat_r  <= i_a[win_idx_s*WIDTH +: WIDTH];
                  b_lat_r  <= i_b[win_idx_s*WIDTH +: WIDTH];
                  id_lat_r <= win_idx_s;
                  ptr_r    <= win_idx_s;
               end else begin
                  o_gnt <= {N_REQ{1'b0}};
               end
            end
            ST_EXEC: begin
               o_gnt   <= {N_REQ{1'b0}};
               o_data  <= nand_f(a_lat_r, b_lat_r);
               o_id    <= id_lat_r;
               o_valid <= 1'b1;
            end
            ST_RESP: begin
               if (i_ready) begin
                  o_valid   <= 1'b0;
                  o_ops_cnt <= o_ops_cnt + 8'd1;
               end else begin
                  o_valid <= 1'b1;
               end
            end
            default: begin
               o_gnt   <= {N_REQ{1'b0}};
               o_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_nand_rr_scheduler.sv
module tb_nand_rr_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] a;
   logic [15:0] b;
   logic        ready;
   logic [3:0]  gnt;
   logic [3:0]  data;
   logic [1:0]  id;
   logic        valid;
   logic        busy;
   logic [7:0]  ops_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int ptr_m    = 3;
   int cnt_m    = 0;
   int data_m   = 0;
   int id_m     = 0;

   always #5 clk = ~clk;

   nand_rr_scheduler #(.WIDTH(4), .N_REQ(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_a(a), .i_b(b),
      .i_ready(ready), .o_gnt(gnt), .o_data(data), .o_id(id),
      .o_valid(valid), .o_busy(busy), .o_ops_cnt(ops_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference round-robin: first requesting index after the last winner, mod 4.
   function automatic int pick(input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (ptr_m + k) % 4;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // Idle cycle with no request: nothing moves.
   task automatic idle_cycle();
      req = 4'b0000;
      a = 16'($urandom);
      b = 16'($urandom);
      ready = 1'($urandom);
      @(posedge clk); #1;
      check("idle_gnt", gnt, 0);
      check("idle_busy", busy, 0);
      check("idle_valid", valid, 0);
      check("idle_data", data, data_m);
      check("idle_cnt", ops_cnt, cnt_m);
   endtask

   // One full operation; delay = cycles in RESP with ready low before the handshake.
   task automatic do_op(input logic [3:0] r, input logic [15:0] av, input logic [15:0] bv, input int delay);
      int win;
      logic [3:0] eg;
      win = pick(r);
      eg = 4'b0000;
      eg[win] = 1'b1;
      req = r; a = av; b = bv; ready = (delay == 0);
      @(posedge clk); #1;
      check("gnt", gnt, eg);
      check("busy_exec", busy, 1);
      check("valid_exec", valid, 0);
      ptr_m  = win;
      data_m = (~((av >> (win*4)) & (bv >> (win*4)))) & 4'hF;
      id_m   = win;
      // Operand/request changes after the grant must not affect the result.
      a = 16'($urandom);
      b = 16'($urandom);
      req = r & ~eg;
      @(posedge clk); #1;
      check("gnt_clear", gnt, 0);
      check("valid", valid, 1);
      check("data", data, data_m);
      check("id", id, id_m);
      for (int d = 0; d < delay; d++) begin
         @(posedge clk); #1;
         check("bp_valid", valid, 1);
         check("bp_data", data, data_m);
         check("bp_id", id, id_m);
         check("bp_gnt", gnt, 0);
      end
      ready = 1'b1;
      @(posedge clk); #1;
      cnt_m = (cnt_m + 1) % 256;
      check("hs_valid", valid, 0);
      check("hs_busy", busy, 0);
      check("hs_cnt", ops_cnt, cnt_m);
      ready = 1'b0;
      req = 4'b0000;
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0000; a = 16'h0000; b = 16'h0000; ready = 1'b0;
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_data", data, 0);
      check("rst_id", id, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", ops_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // All requesters pending: expect grant order 0,1,2,3,0.
      for (int i = 0; i < 5; i++) do_op(4'hF, 16'($urandom), 16'($urandom), 0);

      // Directed single request: 1100 nand 1010 = 0111 from requester 0.
      do_op(4'b0001, 16'h000C, 16'h000A, 0);
      check("dir_data", data, 4'b0111);

      // Backpressure for 5 cycles.
      do_op(4'b0110, 16'($urandom), 16'($urandom), 5);
      repeat (3) idle_cycle();

      // Random traffic, long enough to wrap the handshake counter.
      for (int i = 0; i < 300; i++) begin
         do_op(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) idle_cycle();
      end

      // Reset while a result is pending in RESP.
      req = 4'b0010; a = 16'($urandom); b = 16'($urandom); ready = 1'b0;
      @(posedge clk); #1;
      req = 4'b0000;
      @(posedge clk); #1;
      check("pre_rst_valid", valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", valid, 0);
      check("arst_cnt", ops_cnt, 0);
      check("arst_busy", busy, 0);
      check("arst_data", data, 0);
      ptr_m = 3; cnt_m = 0; data_m = 0; id_m = 0;
      #2 rst_n = 1'b1;
      do_op(4'b0100, 16'($urandom), 16'($urandom), 1);
      check("post_rst_id", id, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
